// File: rtl/registro_temp.sv
// Temperature front end: accepts sensor samples, averages the last four and
// tracks how long the average has stayed outside the normal band.
module registro_temp #(
    parameter logic signed [10:0] TEMP_BAJO    = 11'sd180,
    parameter logic signed [10:0] TEMP_ALTO    = 11'sd250,
    parameter logic signed [10:0] TEMP_RESET   = 11'sd215,
    parameter logic signed [10:0] CODIGO_ERROR = 11'sh400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_valid,
    input  logic signed [10:0] sensor_dato,
    output logic               sensor_ready,
    output logic signed [10:0] temp_registrado,
    output logic [2:0]         contador_fuera_rango,
    output logic               fuera_rango,
    output logic               dato_nuevo,
    output logic               error_sensor
);

    typedef enum logic [1:0] {INICIO, ESPERA, CALC} estado_t;
    typedef enum logic [1:0] {NONE, COLD, HOT} lado_t;

    estado_t estado, estado_sig;
    lado_t   lado, lado_sig;

    logic signed [10:0] w0, w1, w2, w3;
    logic signed [12:0] suma, media13;
    logic signed [10:0] media;
    logic [2:0]         contador_sig;
    logic               aceptar, es_error;

    assign sensor_ready = !rst && (estado != CALC);
    assign aceptar      = sensor_valid && sensor_ready;
    assign es_error     = (sensor_dato == CODIGO_ERROR);

    // Sum of four 11-bit values needs 13 bits; the shift floors toward -inf
    assign suma    = {{2{w0[10]}}, w0} + {{2{w1[10]}}, w1}
                   + {{2{w2[10]}}, w2} + {{2{w3[10]}}, w3};
    assign media13 = suma >>> 2;
    assign media   = media13[10:0];

    always_ff @(posedge clk) begin
        if (rst) estado <= INICIO;
        else     estado <= estado_sig;
    end

    always_comb begin
        estado_sig   = estado;
        lado_sig     = lado;
        contador_sig = contador_fuera_rango;
        case (estado)
            INICIO, ESPERA: begin
                if (aceptar && !es_error) estado_sig = CALC;
            end
            CALC: begin
                estado_sig = ESPERA;
                if (media < TEMP_BAJO) begin
                    lado_sig = COLD;
                    if (lado != COLD)
                        contador_sig = 3'd1;
                    else if (contador_fuera_rango != 3'd7)
                        contador_sig = contador_fuera_rango + 3'd1;
                end else if (media > TEMP_ALTO) begin
                    lado_sig = HOT;
                    if (lado != HOT)
                        contador_sig = 3'd1;
                    else if (contador_fuera_rango != 3'd7)
                        contador_sig = contador_fuera_rango + 3'd1;
                end else begin
                    lado_sig     = NONE;
                    contador_sig = 3'd0;
                end
            end
            default: estado_sig = INICIO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w0                   <= '0;
            w1                   <= '0;
            w2                   <= '0;
            w3                   <= '0;
            lado                 <= NONE;
            temp_registrado      <= TEMP_RESET;
            contador_fuera_rango <= 3'd0;
            fuera_rango          <= 1'b0;
            dato_nuevo           <= 1'b0;
            error_sensor         <= 1'b0;
        end else begin
            dato_nuevo   <= 1'b0;
            error_sensor <= aceptar && es_error;
            // The first good sample fills the whole window so the average starts at it
            if (aceptar && !es_error) begin
                if (estado == INICIO) begin
                    w0 <= sensor_dato;
                    w1 <= sensor_dato;
                    w2 <= sensor_dato;
                    w3 <= sensor_dato;
                end else begin
                    w3 <= w2;
                    w2 <= w1;
                    w1 <= w0;
                    w0 <= sensor_dato;
                end
            end
            if (estado == CALC) begin
                temp_registrado      <= media;
                contador_fuera_rango <= contador_sig;
                lado                 <= lado_sig;
                fuera_rango          <= (lado_sig != NONE);
                dato_nuevo           <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_registro_temp.sv
// Scoreboard bench for registro_temp: a reference model queues the expected
// outputs on each accepted sample and a monitor checks them on dato_nuevo.
module tb_registro_temp;

    logic               clk;
    logic               rst;
    logic               sensor_valid;
    logic signed [10:0] sensor_dato;
    logic               sensor_ready;
    logic signed [10:0] temp_registrado;
    logic [2:0]         contador_fuera_rango;
    logic               fuera_rango;
    logic               dato_nuevo;
    logic               error_sensor;

    registro_temp dut (
        .clk                  (clk),
        .rst                  (rst),
        .sensor_valid         (sensor_valid),
        .sensor_dato          (sensor_dato),
        .sensor_ready         (sensor_ready),
        .temp_registrado      (temp_registrado),
        .contador_fuera_rango (contador_fuera_rango),
        .fuera_rango          (fuera_rango),
        .dato_nuevo           (dato_nuevo),
        .error_sensor         (error_sensor)
    );

    typedef struct {
        int temp;
        int cont;
        int fuera;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   errPending = 0;

    // Reference model state
    int   mw[4];
    int   mLado;
    int   mCont;
    bit   mSeeded;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) mw[i] = 0;
        mLado   = 0;
        mCont   = 0;
        mSeeded = 0;
    endfunction

    // Lado encoding in the model: 0 none, 1 cold, 2 hot
    function automatic void modelAccept(input int d);
        int   s;
        int   avg;
        exp_t e;
        if (d == -1024) begin
            errPending++;
            return;
        end
        if (!mSeeded) begin
            for (int i = 0; i < 4; i++) mw[i] = d;
            mSeeded = 1;
        end else begin
            mw[3] = mw[2];
            mw[2] = mw[1];
            mw[1] = mw[0];
            mw[0] = d;
        end
        s   = mw[0] + mw[1] + mw[2] + mw[3];
        avg = s / 4;
        if (s < 0 && (s % 4) != 0) avg = avg - 1;
        if (avg < 180) begin
            mCont = (mLado == 1) ? ((mCont < 7) ? mCont + 1 : 7) : 1;
            mLado = 1;
        end else if (avg > 250) begin
            mCont = (mLado == 2) ? ((mCont < 7) ? mCont + 1 : 7) : 1;
            mLado = 2;
        end else begin
            mCont = 0;
            mLado = 0;
        end
        e.temp  = avg;
        e.cont  = mCont;
        e.fuera = (mLado != 0) ? 1 : 0;
        sb.push_back(e);
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyReset();
        rst          = 1'b1;
        sensor_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_temp", int'(temp_registrado), 215);
        checkOutput("rst_ready", int'(sensor_ready), 0);
        checkOutput("rst_cont", int'(contador_fuera_rango), 0);
        checkOutput("rst_fuera", int'(fuera_rango), 0);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic applyStimulus(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while (!sensor_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before", int'(sensor_ready), 1);
        sensor_valid = 1'b1;
        sensor_dato  = 11'(d);
        modelAccept(d);
        @(posedge clk);
        #1;
        sensor_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after", int'(sensor_ready), (d == -1024) ? 1 : 0);
    endtask

    // Monitor: compares DUT updates against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dato_nuevo) begin
                if (sb.size() == 0) begin
                    checkOutput("dato_nuevo_unexp", int'(dato_nuevo), 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("temp", int'(temp_registrado), e.temp);
                    checkOutput("cont", int'(contador_fuera_rango), e.cont);
                    checkOutput("fuera", int'(fuera_rango), e.fuera);
                end
            end
            if (error_sensor) begin
                checkOutput("error_sensor", int'(error_sensor), (errPending > 0) ? 1 : 0);
                if (errPending > 0) errPending--;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc;
        rst          = 1'b1;
        sensor_valid = 1'b0;
        sensor_dato  = '0;
        modelReset();

        $display("[TB] basic sample and averaging");
        applyReset();
        applyStimulus(200);
        waitCycles(1);
        checkOutput("t1_temp", int'(temp_registrado), 200);
        applyStimulus(240);
        applyStimulus(240);
        applyStimulus(240);
        waitCycles(2);
        checkOutput("t2_temp", int'(temp_registrado), 230);

        applyReset();
        applyStimulus(-1);
        applyStimulus(-1);
        applyStimulus(-1);
        applyStimulus(-2);
        waitCycles(2);
        checkOutput("t2_floor", int'(temp_registrado), -2);

        $display("[TB] persistence");
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(100);
        waitCycles(2);
        checkOutput("t3_sat", int'(contador_fuera_rango), 7);
        for (int i = 0; i < 4; i++) applyStimulus(250);
        waitCycles(2);
        checkOutput("t3_back", int'(contador_fuera_rango), 0);
        checkOutput("t3_temp", int'(temp_registrado), 250);

        $display("[TB] side switch");
        applyReset();
        applyStimulus(100);
        applyStimulus(100);
        applyStimulus(1000);
        waitCycles(2);
        checkOutput("t4_temp", int'(temp_registrado), 325);
        checkOutput("t4_cont", int'(contador_fuera_rango), 1);

        $display("[TB] error code");
        applyReset();
        applyStimulus(200);
        applyStimulus(-1024);
        waitCycles(2);
        checkOutput("t5_hold", int'(temp_registrado), 200);
        checkOutput("t5_errs", errPending, 0);
        applyStimulus(240);
        waitCycles(2);
        checkOutput("t5_temp", int'(temp_registrado), 210);

        $display("[TB] handshake");
        applyReset();
        acc = 0;
        @(negedge clk);
        sensor_valid = 1'b1;
        sensor_dato  = 11'sd220;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("ready_pat%0d", i), int'(sensor_ready), (i % 2 == 0) ? 1 : 0);
            if (sensor_ready) begin
                modelAccept(220);
                acc++;
            end
        end
        sensor_valid = 1'b0;
        checkOutput("accepts", acc, 2);
        waitCycles(3);

        $display("[TB] reset during calculation");
        applyReset();
        @(negedge clk);
        sensor_valid = 1'b1;
        sensor_dato  = 11'sd300;
        @(posedge clk);
        #1;
        sensor_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_nuevo", int'(dato_nuevo), 0);
        checkOutput("abort_temp", int'(temp_registrado), 215);
        checkOutput("abort_ready", int'(sensor_ready), 0);
        checkOutput("abort_fuera", int'(fuera_rango), 0);
        rst = 1'b0;
        modelReset();
        applyStimulus(240);
        waitCycles(2);
        checkOutput("abort_seed", int'(temp_registrado), 240);

        waitCycles(3);
        checkOutput("sb_drain", sb.size(), 0);
        checkOutput("err_drain", errPending, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
